layer_compositor: RTL

Parametrised, pipelined pixel compositor for the VGA display path. It takes per-layer hit flags from the sprite generators (squares, needles, arrows, life markers) and produces one registered RGB pixel per cycle. It replaces the fixed combinational priority mux with N configurable layers, per-layer colour and display modes (solid/blink/dim/hidden), frame-based blinking, and per-frame collision detection between two layer groups. It sits between the sprite generators and the VGA output register stage.

---
 rtl/compositor_pkg.sv | 23 ++
 rtl/layer_prio_enc.sv | 20 ++
 rtl/layer_compositor.sv | 126 ++++++++++++
 3 files changed

// File: rtl/compositor_pkg.sv
// compositor_pkg: shared layer mode, pixel type and dimming helper for the layer compositor.
package compositor_pkg;

    localparam int CW_DEF = 8;

    typedef enum logic [1:0] {
        LM_SOLID  = 2'd0,
        LM_BLINK  = 2'd1,
        LM_DIM    = 2'd2,
        LM_HIDDEN = 2'd3
    } layer_mode_e;

    typedef struct packed {
        logic [CW_DEF-1:0] r;
        logic [CW_DEF-1:0] g;
        logic [CW_DEF-1:0] b;
    } rgb_t;

    function automatic rgb_t dim_rgb(input rgb_t c);
        return '{r: c.r >> 1, g: c.g >> 1, b: c.b >> 1};
    endfunction

endpackage

// File: rtl/layer_prio_enc.sv
// layer_prio_enc: lowest-index priority encoder; idx = N_LAYERS when no request is set.
module layer_prio_enc #(
    parameter  int N_LAYERS = 8,
    localparam int LW       = $clog2(N_LAYERS + 1)
) (
    input  logic [N_LAYERS-1:0] req,
    output logic [LW-1:0]       idx,
    output logic                found
);
    always_comb begin
        idx   = LW'(N_LAYERS);
        found = 1'b0;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (req[k]) begin
                idx   = LW'(k);
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/layer_compositor.sv
// layer_compositor: two-stage priority compositor with per-layer modes, frame blinking
// and per-frame collision detection between two layer groups.
module layer_compositor
    import compositor_pkg::*;
#(
    parameter  int N_LAYERS     = 8,
    parameter  int CW           = 8,
    parameter  int BLINK_FRAMES = 16,
    localparam int LW           = $clog2(N_LAYERS + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_valid,
    input  logic                               i_frame_start,
    input  logic [N_LAYERS-1:0]                i_layer_hit,
    input  logic [N_LAYERS-1:0][3*CW-1:0]      i_layer_color,
    input  logic [N_LAYERS-1:0][1:0]           i_layer_mode,
    input  logic [3*CW-1:0]                    i_bg_color,
    input  logic [N_LAYERS-1:0]                i_coll_mask_a,
    input  logic [N_LAYERS-1:0]                i_coll_mask_b,
    output logic                               o_valid,
    output logic [3*CW-1:0]                    o_rgb,
    output logic [LW-1:0]                      o_layer,
    output logic                               o_collision,
    output logic                               o_blink_phase
);
    localparam int FCW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;

    logic [FCW-1:0]      frame_cnt;
    logic                phase;
    logic                coll_acc;
    logic                pix_coll;
    logic [N_LAYERS-1:0] shown;
    logic [N_LAYERS-1:0] vis;
    logic [N_LAYERS-1:0] elig;
    logic [LW-1:0]       win_idx;
    logic                win_found;
    logic [3*CW-1:0]     win_color;
    logic                win_dim;
    logic                s1_valid;
    logic [LW-1:0]       s1_idx;
    logic [3*CW-1:0]     s1_color;
    logic                s1_dim;
    logic [3*CW-1:0]     dimmed;

    always_comb begin
        shown = '0;
        vis   = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            shown[k] = i_layer_mode[k] != LM_HIDDEN;
            vis[k]   = shown[k] && !(i_layer_mode[k] == LM_BLINK && !phase);
        end
    end

    assign elig     = i_layer_hit & vis;
    // Collisions ignore blink phase: a blinking sprite still occupies its pixels.
    assign pix_coll = i_valid && |(i_layer_hit & i_coll_mask_a & shown)
                              && |(i_layer_hit & i_coll_mask_b & shown);

    layer_prio_enc #(.N_LAYERS(N_LAYERS)) u_enc (
        .req   (elig),
        .idx   (win_idx),
        .found (win_found)
    );

    // Background is folded into the stage-1 colour so all colours are sampled together.
    always_comb begin
        win_color = i_bg_color;
        win_dim   = 1'b0;
        for (int k = N_LAYERS - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win_color = i_layer_color[k];
                win_dim   = i_layer_mode[k] == LM_DIM;
            end
        end
    end

    generate
        if (CW == CW_DEF) begin : g_pkg_dim
            assign dimmed = dim_rgb(rgb_t'(s1_color));
        end else begin : g_gen_dim
            always_comb begin
                dimmed = '0;
                for (int c = 0; c < 3; c++) dimmed[c*CW +: CW] = s1_color[c*CW +: CW] >> 1;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= LW'(N_LAYERS);
            s1_color <= '0;
            s1_dim   <= 1'b0;
            o_valid  <= 1'b0;
            o_rgb    <= '0;
            o_layer  <= LW'(N_LAYERS);
        end else begin
            s1_valid <= i_valid;
            s1_idx   <= win_idx;
            s1_color <= win_color;
            s1_dim   <= win_found && win_dim;
            o_valid  <= s1_valid;
            o_rgb    <= !s1_valid ? '0 : s1_dim ? dimmed : s1_color;
            o_layer  <= s1_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt   <= '0;
            phase       <= 1'b1;
            coll_acc    <= 1'b0;
            o_collision <= 1'b0;
        end else if (i_frame_start) begin
            frame_cnt   <= frame_cnt == FCW'(BLINK_FRAMES - 1) ? '0 : frame_cnt + 1'b1;
            phase       <= frame_cnt == FCW'(BLINK_FRAMES - 1) ? ~phase : phase;
            o_collision <= coll_acc;
            coll_acc    <= pix_coll;
        end else begin
            coll_acc    <= coll_acc | pix_coll;
        end
    end

    assign o_blink_phase = phase;
endmodule
